// File: rtl/tile_rom_sched.sv
// tile_rom_sched: arbitrates the single 32-bit tile ROM port between the tilemap
// fetch path (strict priority, per-fetch deadline) and CPU RMRD readback
// (bounded wait).  Returned words are registered toward the tile shifter / CPU.
// Optional feature macro: TILE_ROM_SCHED_STATS_EN adds the late_cnt statistic
// (saturating count of late fetches plus overwritten pending fetches).
module tile_rom_sched #(
    parameter int CPU_MAX_WAIT = 3,
    parameter int DEADLINE     = 4
) (
    input  logic        clk_24M,
    input  logic        nRES,
    input  logic        vid_strobe,
    input  logic [17:0] vid_addr,
    output logic [31:0] vid_data,
    output logic        vid_valid,
    output logic        vid_late,
    input  logic        cpu_req,
    input  logic [17:0] cpu_addr,
    output logic [31:0] cpu_data,
    output logic        cpu_ack,
    output logic        mem_req,
    output logic [17:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_dout
`ifdef TILE_ROM_SCHED_STATS_EN
    ,
    output logic [7:0]  late_cnt
`endif
);

    localparam int WAIT_W = (CPU_MAX_WAIT < 1) ? 1 : $clog2(CPU_MAX_WAIT + 1);
    localparam int DL_W   = (DEADLINE < 1) ? 1 : $clog2(DEADLINE + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAX_WAIT);
    localparam logic [DL_W-1:0]   DL_INIT  = DL_W'(DEADLINE);
    localparam logic [DL_W-1:0]   DL_ONE   = DL_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VID  = 2'd1,
        CPU  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                pend_vld;
    logic [17:0]         pend_addr;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                cpu_blk;
    logic [DL_W-1:0]     dl_cnt;
    logic                dl_act;

    logic                cpu_ok;
    logic                vid_avail;
    logic [17:0]         vid_next;
    logic                go_vid, go_cpu, vid_done, cpu_done;
    logic                overwrite, late_evt;

    // A CPU request is serviceable only after cpu_req has dropped since its last issue;
    // a strobe in the same cycle as IDLE arbitration is eligible immediately.
    assign cpu_ok    = cpu_req & ~cpu_blk;
    assign vid_avail = pend_vld | vid_strobe;
    assign vid_next  = vid_strobe ? vid_addr : pend_addr;
    assign overwrite = vid_strobe & pend_vld;
    // The counter tracks the newest fetch; an ack for an older in-flight fetch does not stop it.
    assign late_evt  = dl_act & (dl_cnt == DL_ONE) & ~vid_strobe & ~(vid_done & ~pend_vld);
    assign mem_req   = (state_q != IDLE);

    // FSM state register
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and arbitration: video wins unless the CPU has waited CPU_MAX_WAIT grants
    always_comb begin
        state_d  = state_q;
        go_vid   = 1'b0;
        go_cpu   = 1'b0;
        vid_done = 1'b0;
        cpu_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (vid_avail && ((wait_cnt < WAIT_MAX) || !cpu_ok)) begin
                    go_vid  = 1'b1;
                    state_d = VID;
                end else if (cpu_ok) begin
                    go_cpu  = 1'b1;
                    state_d = CPU;
                end
            end
            VID: begin
                if (mem_ack) begin
                    vid_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            CPU: begin
                if (mem_ack) begin
                    cpu_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue address, held until the transaction completes
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES)       mem_addr <= '0;
        else if (go_vid) mem_addr <= vid_next;
        else if (go_cpu) mem_addr <= cpu_addr;
    end

    // 1-deep video pending register; a later strobe replaces an unissued address
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            pend_vld  <= 1'b0;
            pend_addr <= '0;
        end else if (vid_strobe && !go_vid) begin
            pend_vld  <= 1'b1;
            pend_addr <= vid_addr;
        end else if (go_vid) begin
            pend_vld  <= 1'b0;
        end
    end

    // CPU starvation bookkeeping: grants counted against a waiting request, one issue per cpu_req rise
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            wait_cnt <= '0;
            cpu_blk  <= 1'b0;
        end else begin
            if (!cpu_ok || go_cpu)                  wait_cnt <= '0;
            else if (go_vid && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
            if (!cpu_req)    cpu_blk <= 1'b0;
            else if (go_cpu) cpu_blk <= 1'b1;
        end
    end

    // Deadline counter for the newest video fetch, restarted by every strobe
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            dl_act <= 1'b0;
            dl_cnt <= '0;
        end else if (vid_strobe) begin
            dl_act <= 1'b1;
            dl_cnt <= DL_INIT;
        end else if (vid_done && !pend_vld) begin
            dl_act <= 1'b0;
        end else if (dl_act && dl_cnt != '0) begin
            dl_cnt <= dl_cnt - 1'b1;
        end
    end

    // Returned data and status pulses; late data is still delivered
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES) begin
            vid_data  <= '0;
            vid_valid <= 1'b0;
            vid_late  <= 1'b0;
            cpu_data  <= '0;
            cpu_ack   <= 1'b0;
        end else begin
            vid_valid <= vid_done;
            vid_late  <= late_evt;
            cpu_ack   <= cpu_done;
            if (vid_done) vid_data <= mem_dout;
            if (cpu_done) cpu_data <= mem_dout;
        end
    end

`ifdef TILE_ROM_SCHED_STATS_EN
    // Saturating count of late fetches and overwritten pending fetches
    always_ff @(posedge clk_24M or negedge nRES) begin
        if (!nRES)                                          late_cnt <= '0;
        else if ((late_evt || overwrite) && late_cnt != 8'hFF) late_cnt <= late_cnt + 8'd1;
    end
`endif

endmodule

// File: doc/tile_rom_sched.md
# tile_rom_sched

Scheduler for the single 32-bit tile graphics ROM port in the planes subsystem. It shares the port between the tilemap fetch path, which forms addresses at pixel-slot cadence, and CPU ROM readback through the RMRD window. Video fetches have strict priority and a per-fetch deadline. The CPU side has a bounded-wait guarantee. The block sits between tile address formation and the external ROM/SDRAM bridge, and hands returned words to the planar reorder and tile shifter.

## Interface
Parameters:
- CPU_MAX_WAIT, 3: video grants a waiting CPU request tolerates before it is forced ahead.
- DEADLINE, 4: clk_24M cycles from vid_strobe by which vid_data must be updated.

Ports:
- clk_24M  in  1  system clock; the only clock.
- nRES  in  1  asynchronous active-low reset.
- vid_strobe  in  1  one-cycle pulse; new video fetch address present.
- vid_addr  in  18  video tile ROM word address, sampled on vid_strobe.
- vid_data  out  32  last returned video word, registered.
- vid_valid  out  1  one-cycle pulse when vid_data updates.
- vid_late  out  1  one-cycle pulse when a video fetch misses DEADLINE.
- cpu_req  in  1  level; CPU ROM read requested (RMRD readback active).
- cpu_addr  in  18  CPU ROM word address; stable while cpu_req is high.
- cpu_data  out  32  returned CPU word, registered.
- cpu_ack  out  1  one-cycle pulse; cpu_data valid.
- mem_req  out  1  external port request.
- mem_addr  out  18  external port address.
- mem_ack  in  1  one-cycle pulse; mem_dout valid.
- mem_dout  in  32  external port read data.
- late_cnt  out  8  present only with the stats macro (see Configuration).

## Operation
- **FSM states:**
  - IDLE: no transaction in flight.
  - VID: video transaction outstanding.
  - CPU: CPU transaction outstanding.
- **Video pending register:** vid_strobe loads vid_addr into a 1-deep pending register and starts a deadline counter at DEADLINE.
  - A strobe that arrives while a request is pending but not yet issued replaces the address and restarts the deadline.
  - The overwritten fetch produces no vid_valid.
- **IDLE arbitration:**
  - Video pending and wait_cnt < CPU_MAX_WAIT: go to VID and issue the video request.
  - cpu_req high and (no video pending, or wait_cnt == CPU_MAX_WAIT): go to CPU and issue the CPU request.
  - Otherwise stay in IDLE.
- **wait_cnt:** 2-bit-plus saturating counter.
  - Increments on each video issue while cpu_req is high.
  - Clears on a CPU issue, and whenever cpu_req is low.
- **VID completes on mem_ack:**
  - vid_data <= mem_dout and vid_valid pulses.
  - The data is written even if late.
  - Return to IDLE.
- **CPU completes on mem_ack:**
  - cpu_data <= mem_dout and cpu_ack pulses.
  - Return to IDLE.
  - cpu_req must drop before the next CPU issue. A cpu_req still high on the cycle after cpu_ack is not re-serviced until it falls and rises again.
- **Deadline counter:**
  - Decrements every cycle while a video fetch is pending or in flight.
  - When it reaches 0 before the corresponding mem_ack, vid_late pulses once for that fetch.
- **Bus protocol:** mem_req and mem_addr are held constant from issue until mem_ack. A mem_ack received in IDLE is ignored.

## Timing
- **Reset values:** every output 0; FSM IDLE; pending register, wait_cnt and deadline counter cleared. Reset is asynchronous.
- **Reset mid-transaction:** mem_req drops immediately and the outstanding access is abandoned. A mem_ack arriving after reset release is ignored.
- **Issue latency:** mem_req rises on the cycle after vid_strobe, or after cpu_req is first seen high, when the FSM is in IDLE.
- **Return latency:** vid_data/vid_valid and cpu_data/cpu_ack update on the cycle after mem_ack.
- **Back-to-back:** earliest next issue is the cycle after the data update. This gives a 1-cycle IDLE gap minimum.
- **Simultaneous events:**
  - vid_strobe and mem_ack on the same cycle: both take effect; the new fetch is pending and the old data is delivered.
  - vid_strobe and cpu_req on the same cycle in IDLE with wait_cnt < CPU_MAX_WAIT: the video request is issued first.

## Configuration
- TILE_ROM_SCHED_STATS_EN defined:
  - late_cnt port exists.
  - It is an 8-bit saturating count of vid_late pulses plus overwritten pending fetches.
  - Cleared only by nRES.
- Not defined: port and counter absent. All other behaviour is identical.

## Test plan
- **Video-only, memory 2-cycle latency:** strobe every 4 cycles, addr 0x00010, 0x00011 → mem_addr matches each; vid_valid 4 cycles apart; no vid_late.
- **CPU alone:** cpu_req high, cpu_addr 0x3FFFF, mem_dout 0xDEADBEEF → a single cpu_ack with cpu_data 0xDEADBEEF; no second issue while cpu_req stays high.
- **Starvation bound:** continuous video strobes, memory latency 1, cpu_req held, CPU_MAX_WAIT=3 → CPU issued after exactly 3 video grants; the following video fetch is late (vid_late=1).
- **Deadline miss:** memory latency 6, DEADLINE=4 → vid_late pulses on cycle 4 after strobe; vid_data still updates after mem_ack; with the macro defined, late_cnt=1.
- **Overwrite:** two strobes 1 cycle apart while VID is busy → only the second address is issued; one vid_valid per completed fetch; late_cnt increments by 1 with the macro defined.
- **Reset mid-transaction:** assert nRES low while in CPU state → mem_req and all outputs 0 asynchronously; a stray mem_ack after release produces no cpu_ack.
